// File: rtl/lcd_bus_driver_pkg.sv
// Shared definitions for the HD44780 byte write engine.
//   - HD44780 command constants used by the init ROM and wait selection
//   - FSM state encoding (LCD_STATE_BITS wide)
//   - helper that classifies slow-executing commands (clear / return home)
package lcd_bus_driver_pkg;

    localparam logic [7:0] FUNC_8BIT_2LINE = 8'h38;
    localparam logic [7:0] DISPLAY_ON      = 8'h0C;
    localparam logic [7:0] CLEAR           = 8'h01;
    localparam logic [7:0] ENTRY_INC       = 8'h06;

    localparam int unsigned LCD_STATE_BITS = 3;

    // Index of the last entry in the init ROM
    localparam logic [2:0] INIT_LAST_IDX = 3'd5;

    typedef enum logic [LCD_STATE_BITS-1:0] {
        StPowerWait,
        StInitLoad,
        StSetup,
        StPulse,
        StHold,
        StWait,
        StIdle
    } lcd_state_e;

    // Clear display and return home (0x01..0x03) need the long execution wait
    function automatic logic is_long_cmd(input logic regsel, input logic [7:0] cmd);
        return !regsel && (cmd == 8'h01 || cmd == 8'h02 || cmd == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-on initialisation command ROM for the HD44780.
//   i_index [2:0] : sequence position
//   o_byte  [7:0] : command byte for that position; 0x00 beyond the last entry
module lcd_init_rom
    import lcd_bus_driver_pkg::*;
(
    input  logic [2:0] i_index,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_index)
            3'd0, 3'd1, 3'd2: o_byte = FUNC_8BIT_2LINE;
            3'd3:             o_byte = DISPLAY_ON;
            3'd4:             o_byte = CLEAR;
            3'd5:             o_byte = ENTRY_INC;
            default:          o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 byte write engine. Runs the power-on init sequence, then accepts one
// command/data byte per valid/ready handshake and drives RS, DB[7:0] and E with
// setup, pulse, hold and execution-wait timing.
//   clk, reset (async, active-high)
//   valid, is_data, byte_in[7:0] : byte offer from the string printer
//   ready                        : registered, high in idle after init
//   init_done                    : sticky until reset
//   lcd_regsel, lcd_enable       : HD44780 RS and E
//   lcd_data[7:0]                : HD44780 DB, always driven
module lcd_bus_driver
    import lcd_bus_driver_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 4_000_000,
    parameter int unsigned INIT_WAIT_CYCLES  = 500_000,
    parameter int unsigned SETUP_CYCLES      = 5,
    parameter int unsigned EN_PULSE_CYCLES   = 50,
    parameter int unsigned HOLD_CYCLES       = 5,
    parameter int unsigned SHORT_WAIT_CYCLES = 5_000,
    parameter int unsigned LONG_WAIT_CYCLES  = 200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic       is_data,
    input  logic [7:0] byte_in,
    output logic       ready,
    output logic       init_done,
    output logic       lcd_regsel,
    output logic       lcd_enable,
    inout  wire  [7:0] lcd_data
);

    // Counter reload values: a state lasting N cycles is entered with N-1
    localparam logic [31:0] POWERUP_LOAD = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] INIT_LOAD    = 32'(INIT_WAIT_CYCLES - 1);
    localparam logic [31:0] SETUP_LOAD   = 32'(SETUP_CYCLES - 1);
    localparam logic [31:0] PULSE_LOAD   = 32'(EN_PULSE_CYCLES - 1);
    localparam logic [31:0] HOLD_LOAD    = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] SHORT_LOAD   = 32'(SHORT_WAIT_CYCLES - 1);
    localparam logic [31:0] LONG_LOAD    = 32'(LONG_WAIT_CYCLES - 1);

    lcd_state_e  r_state, w_state_d;
    logic [31:0] r_cnt, w_cnt_d;
    logic [2:0]  r_idx, w_idx_d;
    logic [7:0]  r_data, w_data_d;
    logic        r_regsel, w_regsel_d;
    logic        r_enable, w_enable_d;
    logic        r_ready, w_ready_d;
    logic        r_init_done, w_init_done_d;

    logic [7:0]  w_rom_byte;
    logic [31:0] w_wait_load;
    logic        w_cnt_zero;

    lcd_init_rom u_init_rom (
        .i_index (r_idx),
        .o_byte  (w_rom_byte)
    );

    assign w_cnt_zero = (r_cnt == 32'd0);

    // Execution wait depends on the byte just written (still on the bus in HOLD)
    always_comb begin
        w_wait_load = SHORT_LOAD;
        if (!r_init_done && r_idx == 3'd0) begin
            w_wait_load = INIT_LOAD;
        end else if (is_long_cmd(r_regsel, r_data)) begin
            w_wait_load = LONG_LOAD;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = w_cnt_zero ? r_cnt : r_cnt - 32'd1;
        w_idx_d       = r_idx;
        w_data_d      = r_data;
        w_regsel_d    = r_regsel;
        w_enable_d    = r_enable;
        w_init_done_d = r_init_done;

        unique case (r_state)
            StPowerWait: begin
                if (w_cnt_zero) begin
                    w_state_d = StInitLoad;
                    w_cnt_d   = 32'd0;
                end
            end
            StInitLoad: begin
                w_data_d   = w_rom_byte;
                w_regsel_d = 1'b0;
                w_state_d  = StSetup;
                w_cnt_d    = SETUP_LOAD;
            end
            StSetup: begin
                if (w_cnt_zero) begin
                    w_state_d  = StPulse;
                    w_enable_d = 1'b1;
                    w_cnt_d    = PULSE_LOAD;
                end
            end
            StPulse: begin
                if (w_cnt_zero) begin
                    w_state_d  = StHold;
                    w_enable_d = 1'b0;
                    w_cnt_d    = HOLD_LOAD;
                end
            end
            StHold: begin
                if (w_cnt_zero) begin
                    w_state_d = StWait;
                    w_cnt_d   = w_wait_load;
                end
            end
            StWait: begin
                if (w_cnt_zero) begin
                    w_cnt_d = 32'd0;
                    if (!r_init_done && r_idx != INIT_LAST_IDX) begin
                        w_idx_d   = r_idx + 3'd1;
                        w_state_d = StInitLoad;
                    end else begin
                        w_init_done_d = 1'b1;
                        w_state_d     = StIdle;
                    end
                end
            end
            StIdle: begin
                if (valid && r_ready) begin
                    w_data_d   = byte_in;
                    w_regsel_d = is_data;
                    w_state_d  = StSetup;
                    w_cnt_d    = SETUP_LOAD;
                end
            end
            default: begin
                w_state_d  = StPowerWait;
                w_enable_d = 1'b0;
                w_cnt_d    = POWERUP_LOAD;
            end
        endcase

        w_ready_d = (w_state_d == StIdle) && w_init_done_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StPowerWait;
            r_cnt       <= POWERUP_LOAD;
            r_idx       <= 3'd0;
            r_data      <= 8'h00;
            r_regsel    <= 1'b0;
            r_enable    <= 1'b0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_idx       <= w_idx_d;
            r_data      <= w_data_d;
            r_regsel    <= w_regsel_d;
            r_enable    <= w_enable_d;
            r_ready     <= w_ready_d;
            r_init_done <= w_init_done_d;
        end
    end

    assign ready      = r_ready;
    assign init_done  = r_init_done;
    assign lcd_regsel = r_regsel;
    assign lcd_enable = r_enable;
    assign lcd_data   = r_data;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: the driver issues bytes and pushes the
// expected bus word and ready latency; a negedge monitor checks every E pulse
// and every ready return against those queues.
module tb_lcd_bus_driver;

    localparam int POWERUP = 20;
    localparam int INITW   = 30;
    localparam int SETUP   = 2;
    localparam int PULSE   = 3;
    localparam int HOLD    = 2;
    localparam int SHORTW  = 10;
    localparam int LONGW   = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic       is_data;
    logic [7:0] byte_in;
    logic       ready;
    logic       init_done;
    logic       lcd_regsel;
    logic       lcd_enable;
    wire  [7:0] lcd_data;

    lcd_bus_driver #(
        .POWERUP_CYCLES    (POWERUP),
        .INIT_WAIT_CYCLES  (INITW),
        .SETUP_CYCLES      (SETUP),
        .EN_PULSE_CYCLES   (PULSE),
        .HOLD_CYCLES       (HOLD),
        .SHORT_WAIT_CYCLES (SHORTW),
        .LONG_WAIT_CYCLES  (LONGW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .is_data    (is_data),
        .byte_in    (byte_in),
        .ready      (ready),
        .init_done  (init_done),
        .lcd_regsel (lcd_regsel),
        .lcd_enable (lcd_enable),
        .lcd_data   (lcd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: execution wait per byte, and the init command list
    function automatic int exp_wait(input bit rs, input logic [7:0] b);
        if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return LONGW;
        return SHORTW;
    endfunction

    logic [8:0] init_seq [6];
    logic [8:0] exp_q [$];
    int         lat_q [$];

    bit expect_init;
    bit first_rise;
    int rel_cyc;
    bit stream;
    int prev_rise;
    int prev_acc;
    int acc_cnt = 0;

    task automatic push_init();
        for (int i = 0; i < 6; i++) exp_q.push_back(init_seq[i]);
        expect_init = 1'b1;
        first_rise  = 1'b1;
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0;
    logic       prev_en, prev_rdy;
    logic [8:0] prev_bus, rise_bus, fall_bus, bus;
    int         stable_cnt, high_cnt, hold_left, acc_neg;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_en = 1'b0; prev_rdy = 1'b0; prev_bus = 9'h0;
            stable_cnt = 0; high_cnt = 0; hold_left = 0;
        end else begin
            bus = {lcd_regsel, lcd_data};
            if (bus == prev_bus) stable_cnt++;
            else stable_cnt = 1;

            if (hold_left > 0) begin
                chk("hold_bus", 32'(bus), 32'(fall_bus));
                hold_left--;
            end

            if (lcd_enable && !prev_en) begin
                chk("setup_stable", 32'(stable_cnt > SETUP), 32'd1);
                if (first_rise) begin
                    chk("first_rise_after_reset", 32'(cyc - rel_cyc), 32'(POWERUP + SETUP + 2));
                    first_rise = 1'b0;
                end
                if (stream && prev_rise >= 0)
                    chk("stream_pulse_period", 32'(cyc - prev_rise),
                        32'(SETUP + PULSE + HOLD + SHORTW + 1));
                prev_rise = cyc;
                rise_bus  = bus;
                high_cnt  = 1;
            end else if (lcd_enable) begin
                high_cnt++;
            end

            if (!lcd_enable && prev_en) begin
                chk("pulse_width", 32'(high_cnt), 32'(PULSE));
                chk("bus_steady_in_pulse", 32'(bus), 32'(rise_bus));
                if (exp_q.size() == 0) begin
                    chk("pulse_expected", 32'd0, 32'd1);
                end else begin
                    chk("pulse_bus", 32'(bus), 32'(exp_q.pop_front()));
                end
                fall_bus  = bus;
                hold_left = HOLD;
            end

            if (ready && !prev_rdy) begin
                chk("init_done_with_ready", 32'(init_done), 32'd1);
                if (expect_init) begin
                    chk("init_pulses_consumed", 32'(exp_q.size()), 32'd0);
                    expect_init = 1'b0;
                end else if (lat_q.size() > 0) begin
                    chk("ready_latency", 32'(cyc - acc_neg - 1), 32'(lat_q.pop_front()));
                end else begin
                    chk("ready_rise_expected", 32'd0, 32'd1);
                end
            end

            // valid and ready both stable here; the next posedge is an accept
            if (valid && ready) begin
                exp_q.push_back({is_data, byte_in});
                lat_q.push_back(SETUP + PULSE + HOLD + exp_wait(is_data, byte_in));
                if (stream && prev_acc >= 0)
                    chk("stream_accept_period", 32'(cyc - prev_acc),
                        32'(SETUP + PULSE + HOLD + SHORTW + 1));
                prev_acc = cyc;
                acc_neg  = cyc;
                acc_cnt++;
            end

            prev_en  = lcd_enable;
            prev_rdy = ready;
            prev_bus = bus;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int t = 0;
        while (ready !== 1'b1 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic send(input bit rs, input logic [7:0] b);
        wait_ready();
        is_data = rs;
        byte_in = b;
        valid   = 1'b1;
        @(posedge clk); #1;
        valid   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enable"},    32'(lcd_enable), 32'd0);
        chk({tag, "_ready"},     32'(ready),      32'd0);
        chk({tag, "_init_done"}, 32'(init_done),  32'd0);
        chk({tag, "_regsel"},    32'(lcd_regsel), 32'd0);
        chk({tag, "_data"},      32'(lcd_data),   32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    initial begin
        logic [7:0] rb;
        bit         rrs;
        int         t;
        int         start;
        init_seq[0] = 9'h038; init_seq[1] = 9'h038; init_seq[2] = 9'h038;
        init_seq[3] = 9'h00C; init_seq[4] = 9'h001; init_seq[5] = 9'h006;
        stream = 1'b0; prev_rise = -1; prev_acc = -1;
        reset = 1'b1; valid = 1'b0; is_data = 1'b0; byte_in = 8'h00;
        push_init();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // Power-up quiet time
        t = 0;
        repeat (POWERUP) begin
            @(negedge clk);
            if (lcd_enable) t++;
        end
        chk("powerup_quiet", 32'(t), 32'd0);

        send(1'b1, 8'h41);
        send(1'b0, 8'h01);
        send(1'b0, 8'h80);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);

        // Offer while busy must be ignored
        send(1'b1, 8'h48);
        repeat (4) begin @(posedge clk); #1; end
        chk("busy_not_ready", 32'(ready), 32'd0);
        is_data = 1'b1; byte_in = 8'h55; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;

        // Back-to-back stream
        wait_ready();
        stream = 1'b1; prev_rise = -1; prev_acc = -1;
        start = acc_cnt;
        is_data = 1'b1; byte_in = 8'h48; valid = 1'b1;
        t = 0;
        while (acc_cnt < start + 4 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        valid = 1'b0;
        chk("stream_accepts", 32'(acc_cnt - start), 32'd4);
        wait_ready();
        stream = 1'b0;

        // Random traffic
        for (int i = 0; i < 20; i++) begin
            rrs = 1'($urandom_range(0, 1));
            rb  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(1, 3));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send(rrs, rb);
        end

        // Reset during an enable pulse
        send(1'b1, 8'h5A);
        t = 0;
        while (lcd_enable !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("saw_pulse_before_reset", 32'(lcd_enable), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midpulse_reset");
        exp_q.delete();
        lat_q.delete();
        push_init();
        repeat (2) @(posedge clk);
        release_reset();
        wait_ready();
        send(1'b1, 8'h7E);

        wait_ready();
        repeat (5) @(posedge clk);
        #1;
        chk("final_init_done", 32'(init_done), 32'd1);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("lat_q_drained", 32'(lat_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
